// File: rtl/mc_control32.sv
// Multi-cycle MIPS main control: sequences IF/ID/EX/MEM/WB and drives per-phase write strobes.
// Latency: 3 cycles for jumps and branches, 4 for R/I-type and Jal, 3+MEM_LAT for Sw and 4+MEM_LAT for Lw to RAM.
// Backpressure: IO accesses stall in MEM until io_ready, or abort after IO_TIMEOUT cycles and set io_err.
//
// Ports:
//   clock, rst_n                 rising-edge clock, synchronous active-low reset
//   Opcode, Function_opcode      instruction fields from the IR, decoded during ID
//   Alu_resultHigh, Zero         ALU feedback (IO address decode, branch condition)
//   io_ready                     IO device completion level
//   IRWrite..IOWrite             one-phase strobes to the datapath
//   RegDST..Sftmd, ALUOp         decode registered at the end of ID
//   io_err                       sticky IO timeout flag
//   state                        current FSM state (IF=0 ID=1 EX=2 MEM=3 WB=4)
module mc_control32 #(
  parameter int                   ADDR_HI_W  = 22,
  parameter logic [ADDR_HI_W-1:0] IO_BASE_HI = {ADDR_HI_W{1'b1}},
  parameter int                   MEM_LAT    = 1,
  parameter int                   IO_TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [5:0]           Opcode,
  input  logic [5:0]           Function_opcode,
  input  logic [ADDR_HI_W-1:0] Alu_resultHigh,
  input  logic                 Zero,
  input  logic                 io_ready,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 PCSrcJump,
  output logic                 RegWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IORead,
  output logic                 IOWrite,
  output logic                 RegDST,
  output logic                 ALUSrc,
  output logic                 MemorIOtoReg,
  output logic                 Jal,
  output logic                 Jrn,
  output logic                 I_format,
  output logic                 Sftmd,
  output logic [1:0]           ALUOp,
  output logic                 io_err,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t     cur_state, nxt_state;

  // Instruction class flags captured with the visible decode outputs.
  logic       r_fmt_q, lw_q, sw_q, br_q, nbr_q, jmp_q;
  logic       io_sel;
  logic [3:0] lat_cnt;
  logic [7:0] io_cnt;
  logic       io_timeout;
  logic       mem_done;
  logic       redirect;

  // Combinational decode of the IR fields, sampled only at the end of ID.
  logic dec_r, dec_lw, dec_sw, dec_i;
  always_comb begin
    dec_r  = (Opcode == 6'h00);
    dec_lw = (Opcode == 6'h23);
    dec_sw = (Opcode == 6'h2B);
    dec_i  = (Opcode[5:3] == 3'b001);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cur_state    <= S_IF;
      r_fmt_q      <= 1'b0;
      lw_q         <= 1'b0;
      sw_q         <= 1'b0;
      br_q         <= 1'b0;
      nbr_q        <= 1'b0;
      jmp_q        <= 1'b0;
      RegDST       <= 1'b0;
      ALUSrc       <= 1'b0;
      MemorIOtoReg <= 1'b0;
      Jal          <= 1'b0;
      Jrn          <= 1'b0;
      I_format     <= 1'b0;
      Sftmd        <= 1'b0;
      ALUOp        <= 2'b00;
      io_sel       <= 1'b0;
      lat_cnt      <= 4'd0;
      io_cnt       <= 8'd0;
      io_err       <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_ID) begin
        r_fmt_q      <= dec_r;
        lw_q         <= dec_lw;
        sw_q         <= dec_sw;
        br_q         <= (Opcode == 6'h04);
        nbr_q        <= (Opcode == 6'h05);
        jmp_q        <= (Opcode == 6'h02);
        RegDST       <= dec_r;
        ALUSrc       <= dec_i | dec_lw | dec_sw;
        MemorIOtoReg <= dec_lw;
        Jal          <= (Opcode == 6'h03);
        Jrn          <= dec_r & (Function_opcode == 6'h08);
        I_format     <= dec_i;
        Sftmd        <= dec_r & (Function_opcode[5:3] == 3'b000);
        ALUOp        <= {dec_r | dec_i, (Opcode == 6'h04) | (Opcode == 6'h05)};
      end
      // Space select is frozen on the edge into MEM so a wandering ALU
      // result cannot switch targets mid-access.
      if (cur_state == S_EX) begin
        io_sel  <= (Alu_resultHigh == IO_BASE_HI);
        lat_cnt <= 4'd0;
        io_cnt  <= 8'd0;
      end else if (cur_state == S_MEM) begin
        lat_cnt <= lat_cnt + 4'd1;
        io_cnt  <= io_cnt + 8'd1;
      end
      if (io_timeout) begin
        io_err <= 1'b1;
      end
    end
  end

  always_comb begin
    nxt_state  = cur_state;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrcJump  = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IORead     = 1'b0;
    IOWrite    = 1'b0;
    io_timeout = 1'b0;
    mem_done   = 1'b0;
    redirect   = jmp_q | Jrn | Jal | (br_q & Zero) | (nbr_q & ~Zero);
    // Strobes are suppressed while reset is held so an aborted access
    // never leaks into the reset window.
    if (rst_n) begin
      case (cur_state)
        S_IF: begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          nxt_state = S_ID;
        end
        S_ID: begin
          nxt_state = S_EX;
        end
        S_EX: begin
          if (redirect) begin
            PCWrite   = 1'b1;
            PCSrcJump = 1'b1;
          end
          if (Jal) begin
            nxt_state = S_WB;
          end else if (jmp_q | Jrn | br_q | nbr_q) begin
            nxt_state = S_IF;
          end else if (lw_q | sw_q) begin
            nxt_state = S_MEM;
          end else if (r_fmt_q | I_format) begin
            nxt_state = S_WB;
          end else begin
            nxt_state = S_IF;
          end
        end
        S_MEM: begin
          if (io_sel) begin
            IORead  = lw_q;
            IOWrite = sw_q;
            if (io_ready) begin
              mem_done = 1'b1;
            end else if (io_cnt == 8'(IO_TIMEOUT - 1)) begin
              io_timeout = 1'b1;
              mem_done   = 1'b1;
            end
          end else begin
            MemRead  = lw_q;
            MemWrite = sw_q;
            if (lat_cnt == 4'(MEM_LAT - 1)) begin
              mem_done = 1'b1;
            end
          end
          if (mem_done) begin
            nxt_state = (lw_q & ~io_timeout) ? S_WB : S_IF;
          end
        end
        S_WB: begin
          RegWrite  = 1'b1;
          nxt_state = S_IF;
        end
        default: begin
          nxt_state = S_IF;
        end
      endcase
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_mc_control32.sv
module tb_mc_control32;

  localparam int          MEM_LAT = 2;
  localparam int          IO_TO   = 8;
  localparam logic [21:0] IO_HI   = 22'h3FFFFF;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  Opcode = 6'd0;
  logic [5:0]  Function_opcode = 6'd0;
  logic [21:0] Alu_resultHigh = 22'd0;
  logic        Zero = 1'b0;
  logic        io_ready = 1'b0;
  logic        IRWrite, PCWrite, PCSrcJump, RegWrite;
  logic        MemRead, MemWrite, IORead, IOWrite;
  logic        RegDST, ALUSrc, MemorIOtoReg, Jal, Jrn, I_format, Sftmd;
  logic [1:0]  ALUOp;
  logic        io_err;
  logic [2:0]  state;

  always #5 clock = ~clock;

  mc_control32 #(
    .ADDR_HI_W (22),
    .IO_BASE_HI(IO_HI),
    .MEM_LAT   (MEM_LAT),
    .IO_TIMEOUT(IO_TO)
  ) dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .Opcode         (Opcode),
    .Function_opcode(Function_opcode),
    .Alu_resultHigh (Alu_resultHigh),
    .Zero           (Zero),
    .io_ready       (io_ready),
    .IRWrite        (IRWrite),
    .PCWrite        (PCWrite),
    .PCSrcJump      (PCSrcJump),
    .RegWrite       (RegWrite),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .IORead         (IORead),
    .IOWrite        (IOWrite),
    .RegDST         (RegDST),
    .ALUSrc         (ALUSrc),
    .MemorIOtoReg   (MemorIOtoReg),
    .Jal            (Jal),
    .Jrn            (Jrn),
    .I_format       (I_format),
    .Sftmd          (Sftmd),
    .ALUOp          (ALUOp),
    .io_err         (io_err),
    .state          (state)
  );

  // strb = {IRWrite,PCWrite,PCSrcJump,RegWrite,MemRead,MemWrite,IORead,IOWrite}
  // dec  = {RegDST,ALUSrc,MemorIOtoReg,Jal,Jrn,I_format,Sftmd,ALUOp}
  typedef struct packed {
    logic [2:0] st;
    logic [7:0] strb;
    logic       err;
    logic       chk_dec;
    logic [8:0] dec;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic model_err = 1'b0;

  // Decode equations of the single-cycle main decoder.
  function automatic logic [8:0] ref_decode(input logic [5:0] op, input logic [5:0] fn);
    logic r, lw, sw, i;
    r  = (op == 6'h00);
    lw = (op == 6'h23);
    sw = (op == 6'h2B);
    i  = (op[5:3] == 3'b001);
    return {r, i | lw | sw, lw, op == 6'h03, r && fn == 6'h08, i,
            r && fn[5:3] == 3'b000, r | i, op == 6'h04 || op == 6'h05};
  endfunction

  // One instruction, expressed as a list of phases with the strobes each
  // phase must show. abort_at < 0 runs it to completion.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic [21:0] ahi, input logic z,
                           input int rdy_delay, input int abort_at);
    logic       r, jr, jmp, jal, taken, lw, sw, alu, io, tmo, wb;
    int         nmem, total, midx;
    logic [2:0] st;
    logic [7:0] strb;
    logic [8:0] dec;
    r     = (op == 6'h00);
    jr    = r && fn == 6'h08;
    jmp   = (op == 6'h02) || jr;
    jal   = (op == 6'h03);
    taken = (op == 6'h04 && z) || (op == 6'h05 && !z);
    lw    = (op == 6'h23);
    sw    = (op == 6'h2B);
    alu   = (r && !jr) || op[5:3] == 3'b001;
    io    = (ahi == IO_HI);
    tmo   = 1'b0;
    nmem  = 0;
    if (lw || sw) begin
      if (!io) nmem = MEM_LAT;
      else if (rdy_delay < IO_TO) nmem = rdy_delay + 1;
      else begin
        nmem = IO_TO;
        tmo  = 1'b1;
      end
    end
    wb    = alu || jal || (lw && !tmo);
    total = 3 + nmem + (wb ? 1 : 0);
    dec   = ref_decode(op, fn);
    Opcode = op;
    Function_opcode = fn;
    Alu_resultHigh = ahi;
    Zero = z;
    for (int i = 0; i < total; i++) begin
      if (i == abort_at) return;
      if (i < 3) st = 3'(i);
      else if (i < 3 + nmem) st = 3'd3;
      else st = 3'd4;
      midx = i - 3;
      if (st == 3'd3 && io) io_ready = (midx >= rdy_delay);
      else io_ready = 1'($urandom);
      strb = 8'b0;
      case (st)
        3'd0: strb = 8'b1100_0000;
        3'd2: if (jmp || jal || taken) strb = 8'b0110_0000;
        3'd3: strb = io ? {6'b0, lw, sw} : {4'b0, lw, sw, 2'b0};
        3'd4: strb = 8'b0001_0000;
        default: strb = 8'b0;
      endcase
      sb.push_back('{st: st, strb: strb, err: model_err, chk_dec: (i >= 2), dec: dec});
      if (st == 3'd3 && midx == nmem - 1 && tmo) model_err = 1'b1;
      @(posedge clock);
      #1;
    end
  endtask

  // Caller is 1 time unit after an edge; the first reset cycle still shows
  // st0 (state register not yet reset) but strobes must already be quiet.
  task automatic apply_reset(input int n, input logic [2:0] st0);
    for (int c = 0; c < n; c++) begin
      rst_n = 1'b0;
      Opcode = 6'($urandom);
      Function_opcode = 6'($urandom);
      Alu_resultHigh = IO_HI;
      Zero = 1'($urandom);
      io_ready = 1'($urandom);
      sb.push_back('{st: (c == 0) ? st0 : 3'd0, strb: 8'b0, err: model_err,
                     chk_dec: (c > 0), dec: 9'b0});
      @(posedge clock);
      #1;
      model_err = 1'b0;
    end
    rst_n = 1'b1;
  endtask

  exp_t       mon_e;
  logic [7:0] act_strb;
  logic [8:0] act_dec;

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_e    = sb.pop_front();
      act_strb = {IRWrite, PCWrite, PCSrcJump, RegWrite, MemRead, MemWrite, IORead, IOWrite};
      act_dec  = {RegDST, ALUSrc, MemorIOtoReg, Jal, Jrn, I_format, Sftmd, ALUOp};
      vectors++;
      if (state !== mon_e.st || act_strb !== mon_e.strb || io_err !== mon_e.err ||
          (mon_e.chk_dec && act_dec !== mon_e.dec)) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t got state=%0d strb=%b err=%b dec=%b expected state=%0d strb=%b err=%b dec=%b dec_checked=%0b",
                 $time, state, act_strb, io_err, act_dec,
                 mon_e.st, mon_e.strb, mon_e.err, mon_e.dec, mon_e.chk_dec);
      end
    end
  end

  logic [5:0] ops[16] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h23, 6'h2B, 6'h2B, 6'h04,
                          6'h05, 6'h02, 6'h03, 6'h08, 6'h0D, 6'h0F, 6'h3F, 6'h10};
  logic [5:0] fns[8]  = '{6'h20, 6'h08, 6'h00, 6'h02, 6'h2A, 6'h22, 6'h03, 6'h21};

  initial begin
    logic [5:0]  op;
    logic [21:0] ahi;
    rst_n = 1'b0;
    @(posedge clock);
    #1;
    apply_reset(2, 3'd0);

    run_instr(6'h00, 6'h20, 22'd0, 1'b0, 0, -1);    // add
    run_instr(6'h23, 6'h00, 22'd0, 1'b0, 0, -1);    // lw RAM
    run_instr(6'h2B, 6'h00, IO_HI, 1'b0, 5, -1);    // sw IO, ready after 5
    run_instr(6'h23, 6'h00, IO_HI, 1'b0, 1000, -1); // lw IO timeout
    run_instr(6'h00, 6'h20, 22'd0, 1'b0, 0, -1);    // fetch after timeout
    run_instr(6'h04, 6'h00, 22'd0, 1'b1, 0, -1);    // beq taken
    run_instr(6'h04, 6'h00, 22'd0, 1'b0, 0, -1);    // beq not taken
    run_instr(6'h05, 6'h00, 22'd0, 1'b1, 0, -1);    // bne not taken
    run_instr(6'h05, 6'h00, 22'd0, 1'b0, 0, -1);    // bne taken
    run_instr(6'h03, 6'h00, 22'd0, 1'b0, 0, -1);    // jal
    run_instr(6'h02, 6'h00, 22'd0, 1'b0, 0, -1);    // j
    run_instr(6'h00, 6'h08, 22'd0, 1'b0, 0, -1);    // jr
    run_instr(6'h23, 6'h00, IO_HI, 1'b0, 0, -1);    // lw IO ready at once
    run_instr(6'h23, 6'h00, IO_HI, 1'b0, IO_TO - 1, -1); // ready on last allowed cycle
    run_instr(6'h2B, 6'h00, 22'h1234, 1'b0, 0, -1); // sw RAM
    run_instr(6'h08, 6'h00, 22'd0, 1'b0, 0, -1);    // addi
    run_instr(6'h3F, 6'h00, 22'd0, 1'b0, 0, -1);    // undefined opcode

    for (int k = 0; k < 200; k++) begin
      op  = ops[$urandom_range(0, 15)];
      ahi = ($urandom_range(0, 1) == 1) ? IO_HI : 22'($urandom);
      run_instr(op, fns[$urandom_range(0, 7)], ahi, 1'($urandom),
                $urandom_range(0, 10), -1);
    end

    // Reset in the middle of an IO wait, after an earlier timeout set io_err.
    run_instr(6'h23, 6'h00, IO_HI, 1'b0, 1000, -1);
    run_instr(6'h23, 6'h00, IO_HI, 1'b0, 1000, 7);
    apply_reset(2, 3'd3);
    run_instr(6'h00, 6'h20, 22'd0, 1'b0, 0, -1);

    @(negedge clock);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain got %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
